// File: rtl/zx_key_serial_tx_pkg.sv
// zx_kbd_pkg: shared widths, special key addresses, event record and FSM state codes
// for the CH446Q-style keyboard serial link transmitter.
package zx_kbd_pkg;
    localparam int AX_W   = 4;
    localparam int AY_W   = 3;
    localparam int ADDR_W = AY_W + AX_W;
    localparam logic [ADDR_W-1:0] KEY_MAGIC = 7'h58;
    localparam logic [ADDR_W-1:0] KEY_RESET = 7'h68;
    localparam logic [ADDR_W-1:0] KEY_PAUSE = 7'h78;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              on;
    } key_evt_t;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_BIT_LO   = 3'd1;
    localparam logic [2:0] ST_BIT_HI   = 3'd2;
    localparam logic [2:0] ST_DAT_SET  = 3'd3;
    localparam logic [2:0] ST_STB_HI   = 3'd4;
    localparam logic [2:0] ST_STB_HOLD = 3'd5;
    localparam logic [2:0] ST_GAP      = 3'd6;
    function automatic logic [ADDR_W-1:0] key_addr(input logic [AY_W-1:0] ay, input logic [AX_W-1:0] ax);
        return {ay, ax};
    endfunction
endpackage

// File: rtl/zx_key_serial_tx_if.sv
// zx_key_serial_tx_if: key-event valid/ready port.
//   ev_valid/ev_addr/ev_on driven by the producer (master), ev_ready by the transmitter (slave).
interface zx_key_serial_tx_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [6:0] ev_addr;
    logic       ev_on;
    modport master (output ev_valid, output ev_addr, output ev_on, input ev_ready);
    modport slave  (input ev_valid, input ev_addr, input ev_on, output ev_ready);
endinterface

// File: rtl/zx_key_serial_tx_fifo.sv
// zx_evt_fifo: synchronous FIFO of key events.
//   clk, rst_in (async active-low clear), flush (sync clear, beats push/pop),
//   push/wdata, pop/rdata (rdata shows the head combinationally), full, empty, count.
module zx_evt_fifo
    import zx_kbd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  key_evt_t               wdata,
    output key_evt_t               rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    key_evt_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rptr];
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/zx_key_serial_tx.sv
// zx_key_serial_tx: queues key-switch events and serialises each as a DAT/SK/STB frame.
//   clk, rst_in (async active-low), ev (valid/ready event port), flush (drop queued events),
//   busy, fifo_count (queued events), DAT/SK/STB (registered serial link to the CPLD).
module zx_key_serial_tx
    import zx_kbd_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_TICKS  = 2
) (
    input  logic                        clk,
    input  logic                        rst_in,
    zx_key_serial_tx_if.slave           ev,
    input  logic                        flush,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        DAT,
    output logic                        SK,
    output logic                        STB
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int GW = GAP_TICKS > 1 ? $clog2(GAP_TICKS) : 1;
    key_evt_t head, evt, evt_n;
    logic full, empty, pop, tick, frame_end;
    logic [2:0] st, st_n, bit_q, bit_n;
    logic [DW-1:0] div;
    logic [GW-1:0] gcnt, gcnt_n;
    zx_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_in(rst_in),
        .flush (flush),
        .push  (ev.ev_valid),
        .pop   (pop),
        .wdata (key_evt_t'({ev.ev_addr, ev.ev_on})),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
    assign ev.ev_ready = rst_in && !full;
    assign busy        = st != ST_IDLE || !empty;
    assign tick        = div == DW'(CLK_DIV - 1);
    // The last gap tick doubles as the next frame's pop so frames run back to back.
    assign frame_end   = st == ST_IDLE || (tick && st == ST_GAP && gcnt == GW'(GAP_TICKS - 1));
    always_comb begin
        st_n   = st;
        bit_n  = bit_q;
        gcnt_n = gcnt;
        pop    = 1'b0;
        if (frame_end) begin
            pop   = !empty && !flush;
            st_n  = pop ? ST_BIT_LO : ST_IDLE;
            bit_n = 3'd6;
        end else if (tick) begin
            case (st)
                ST_BIT_LO:   st_n = ST_BIT_HI;
                ST_BIT_HI: begin
                    st_n  = bit_q == 3'd0 ? ST_DAT_SET : ST_BIT_LO;
                    bit_n = bit_q == 3'd0 ? bit_q : bit_q - 3'd1;
                end
                ST_DAT_SET:  st_n = ST_STB_HI;
                ST_STB_HI:   st_n = ST_STB_HOLD;
                ST_STB_HOLD: begin
                    st_n   = ST_GAP;
                    gcnt_n = '0;
                end
                ST_GAP:      gcnt_n = gcnt + GW'(1);
                default:     st_n = ST_IDLE;
            endcase
        end
        evt_n = pop ? head : evt;
    end
    // Outputs are registered from the next state so each pin changes exactly on a tick boundary.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            st    <= ST_IDLE;
            bit_q <= '0;
            gcnt  <= '0;
            div   <= '0;
            evt   <= '0;
            DAT   <= 1'b0;
            SK    <= 1'b0;
            STB   <= 1'b0;
        end else begin
            st    <= st_n;
            bit_q <= bit_n;
            gcnt  <= gcnt_n;
            evt   <= evt_n;
            div   <= (st == ST_IDLE || tick) ? '0 : div + DW'(1);
            SK    <= st_n == ST_BIT_HI;
            STB   <= st_n == ST_STB_HI;
            DAT   <= (st_n == ST_BIT_LO || st_n == ST_BIT_HI) ? evt_n.addr[bit_n] :
                     (st_n == ST_DAT_SET || st_n == ST_STB_HI || st_n == ST_STB_HOLD) ? evt_n.on : 1'b0;
        end
    end
endmodule

// File: tb/tb_zx_key_serial_tx.sv
// tb_zx_key_serial_tx: directed bench with a receiver/protocol model for two transmitters (CLK_DIV 4 and 1).
module tb_zx_key_serial_tx;
    import zx_kbd_pkg::*;
    logic clk = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk = ~clk;
    zx_key_serial_tx_if ev0 ();
    zx_key_serial_tx_if ev1 ();
    logic flush0 = 1'b0, flush1 = 1'b0;
    logic busy0, busy1, dat0, dat1, sk0, sk1, stb0, stb1;
    logic [3:0] fifo_count0, fifo_count1;
    zx_key_serial_tx #(.CLK_DIV(4), .FIFO_DEPTH(8), .GAP_TICKS(2)) dut0 (
        .clk(clk), .rst_in(rst_in), .ev(ev0), .flush(flush0), .busy(busy0),
        .fifo_count(fifo_count0), .DAT(dat0), .SK(sk0), .STB(stb0));
    zx_key_serial_tx #(.CLK_DIV(1), .FIFO_DEPTH(8), .GAP_TICKS(2)) dut1 (
        .clk(clk), .rst_in(rst_in), .ev(ev1), .flush(flush1), .busy(busy1),
        .fifo_count(fifo_count1), .DAT(dat1), .SK(sk1), .STB(stb1));

    int n_chk = 0, n_pass = 0, viol = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // receiver model: shifts DAT on SK rise, latches the switch on STB rise
    logic [1:0] dat_v, sk_v, stb_v;
    assign dat_v = {dat1, dat0};
    assign sk_v  = {sk1, sk0};
    assign stb_v = {stb1, stb0};
    logic [6:0] sh [2];
    logic psk [2], pstb [2], pdat [2];
    int skc [2] = '{0, 0}, skrun [2] = '{0, 0}, stbrun [2] = '{0, 0}, rxn [2] = '{0, 0};
    logic [6:0] rx_addr [2][64];
    logic rx_on [2][64], rx_off [2][64];
    int rx_t [2][64];
    logic mat [2][128] = '{default: 1'b0};
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_in) begin
                skrun[k]  = 0;
                stbrun[k] = 0;
            end else begin
                if (sk_v[k] && !psk[k]) begin
                    if (stb_v[k] || dat_v[k] !== pdat[k]) viol++;
                    sh[k] = {sh[k][5:0], dat_v[k]};
                    skc[k]++;
                end
                if (!sk_v[k] && psk[k] && skrun[k] != (k == 0 ? 4 : 1)) viol++;
                if (stb_v[k] && !pstb[k]) begin
                    if (sk_v[k] || dat_v[k] !== pdat[k]) viol++;
                    if (rxn[k] < 64) begin
                        rx_addr[k][rxn[k]] = sh[k];
                        rx_on[k][rxn[k]]   = dat_v[k];
                        rx_t[k][rxn[k]]    = cyc;
                    end
                    rxn[k]++;
                    mat[k][sh[k]] = dat_v[k];
                end
                if (!stb_v[k] && pstb[k]) begin
                    if (rxn[k] > 0 && rxn[k] <= 64) rx_off[k][rxn[k]-1] = dat_v[k];
                    if (stbrun[k] != (k == 0 ? 4 : 1)) viol++;
                end
                skrun[k]  = sk_v[k] ? skrun[k] + 1 : 0;
                stbrun[k] = stb_v[k] ? stbrun[k] + 1 : 0;
            end
            psk[k]  = sk_v[k];
            pstb[k] = stb_v[k];
            pdat[k] = dat_v[k];
        end
    end

    task automatic push(input int k, input logic [6:0] a, input logic on);
        int n = 0;
        if (k == 0) begin
            ev0.ev_valid = 1'b1; ev0.ev_addr = a; ev0.ev_on = on;
        end else begin
            ev1.ev_valid = 1'b1; ev1.ev_addr = a; ev1.ev_on = on;
        end
        while (!(k == 0 ? ev0.ev_ready : ev1.ev_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        ev0.ev_valid = 1'b0;
        ev1.ev_valid = 1'b0;
    endtask

    task automatic wait_idle(input int k, output int n);
        n = 0;
        while ((k == 0 ? busy0 : busy1) && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    logic [6:0] t2a [10] = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66, 7'h77, 7'h08, 7'h19, 7'h2A};
    logic       t2o [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int n, base, s;
        ev0.ev_valid = 1'b0; ev0.ev_addr = '0; ev0.ev_on = 1'b0;
        ev1.ev_valid = 1'b0; ev1.ev_addr = '0; ev1.ev_on = 1'b0;
        @(negedge clk);
        check("rst_dat", dat0, 0);
        check("rst_sk", sk0, 0);
        check("rst_stb", stb0, 0);
        check("rst_busy", busy0, 0);
        check("rst_count", fifo_count0, 0);
        check("rst_ready", ev0.ev_ready, 0);
        repeat (2) @(negedge clk);
        #2 rst_in = 1'b1;
        @(negedge clk);
        check("ready_after_rst", ev0.ev_ready, 1);

        // single frame
        base = rxn[0]; s = skc[0];
        push(0, 7'h02, 1'b1);
        wait_idle(0, n);
        check("t1_busy_clks", n, 77);
        check("t1_sk_rises", skc[0] - s, 7);
        check("t1_frames", rxn[0] - base, 1);
        check("t1_addr", rx_addr[0][base], 7'h02);
        check("t1_stb_rise_dat", rx_on[0][base], 1);
        check("t1_stb_fall_dat", rx_off[0][base], 1);
        check("t1_matrix", mat[0][2], 1);

        // fill the FIFO while the first frame stalls it
        base = rxn[0];
        for (int i = 0; i < 10; i++) begin
            ev0.ev_valid = 1'b1; ev0.ev_addr = t2a[i]; ev0.ev_on = t2o[i];
            check($sformatf("t2_ready%0d", i), ev0.ev_ready, i < 9);
            if (i == 9) check("t2_count_full", fifo_count0, 8);
            @(negedge clk);
        end
        ev0.ev_valid = 1'b0;
        wait_idle(0, n);
        check("t2_idle", n < 3000, 1);
        check("t2_frames", rxn[0] - base, 9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t2_addr%0d", i), rx_addr[0][base+i], t2a[i]);
            check($sformatf("t2_on%0d", i), rx_on[0][base+i], t2o[i]);
            check($sformatf("t2_matrix%0d", i), mat[0][t2a[i]], t2o[i]);
            if (i > 0) check($sformatf("t2_spacing%0d", i), rx_t[0][base+i] - rx_t[0][base+i-1], 76);
        end

        // special line RESET on then off
        base = rxn[0];
        push(0, KEY_RESET, 1'b1);
        push(0, KEY_RESET, 1'b0);
        wait_idle(0, n);
        check("t3_frames", rxn[0] - base, 2);
        check("t3_addr0", rx_addr[0][base], 7'b1101000);
        check("t3_addr1", rx_addr[0][base+1], 7'b1101000);
        check("t3_on0", rx_on[0][base], 1);
        check("t3_on1", rx_on[0][base+1], 0);
        check("t3_off1", rx_off[0][base+1], 0);
        check("t3_matrix", mat[0][7'h68], 0);

        // reset in the middle of bit 3
        base = rxn[0]; s = skc[0];
        push(0, 7'h4D, 1'b1);
        n = 0;
        while (skc[0] < s + 4 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("t4_pre_sk", sk0, 1);
        check("t4_pre_dat", dat0, 1);
        #2 rst_in = 1'b0;
        #1;
        check("t4_dat", dat0, 0);
        check("t4_sk", sk0, 0);
        check("t4_stb", stb0, 0);
        check("t4_busy", busy0, 0);
        check("t4_count", fifo_count0, 0);
        repeat (3) @(negedge clk);
        #2 rst_in = 1'b1;
        repeat (150) @(negedge clk);
        check("t4_no_stb", rxn[0] - base, 0);
        check("t4_matrix", mat[0][7'h4D], 0);
        check("t4_idle", busy0, 0);

        // flush during the first of five queued frames
        base = rxn[0];
        for (int i = 1; i <= 5; i++) push(0, 7'(i), 1'b1);
        check("t5_count_before", fifo_count0, 4);
        flush0 = 1'b1;
        @(negedge clk);
        flush0 = 1'b0;
        check("t5_count_after", fifo_count0, 0);
        check("t5_busy_in_flight", busy0, 1);
        wait_idle(0, n);
        repeat (200) @(negedge clk);
        check("t5_frames", rxn[0] - base, 1);
        check("t5_addr", rx_addr[0][base], 7'h01);
        check("t5_on", rx_on[0][base], 1);

        // flush wins against a concurrent push
        base = rxn[0];
        ev0.ev_valid = 1'b1; ev0.ev_addr = 7'h70; ev0.ev_on = 1'b1; flush0 = 1'b1;
        @(negedge clk);
        ev0.ev_valid = 1'b0; flush0 = 1'b0;
        check("flush_push_count", fifo_count0, 0);
        check("flush_push_busy", busy0, 0);
        repeat (100) @(negedge clk);
        check("flush_push_frames", rxn[0] - base, 0);

        // CLK_DIV = 1 instance
        base = rxn[1]; s = skc[1];
        push(1, 7'h3A, 1'b1);
        wait_idle(1, n);
        check("t6_busy_clks", n, 20);
        check("t6_sk_rises", skc[1] - s, 7);
        check("t6_frames", rxn[1] - base, 1);
        check("t6_addr", rx_addr[1][base], 7'h3A);
        check("t6_on", rx_on[1][base], 1);
        check("t6_off", rx_off[1][base], 1);
        check("t6_matrix", mat[1][7'h3A], 1);

        check("protocol_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
